// File: rtl/buscaminas_board_if.sv
// Command/response bundle between the minesweeper controller (master) and
// the board-state responder buscaminas_board (slave).
interface buscaminas_board_if;
   logic       cmd_restart;
   logic       cmd_move;
   logic [1:0] dir;
   logic       cmd_flag;
   logic       cmd_query;
   logic       cmd_clear;
   logic       hbo;
   logic       hba;
   logic       rsp_valid;
   logic       last_cell;
   logic       busy;
   logic [3:0] cur_row;
   logic [3:0] cur_col;
   logic [3:0] neigh_count;
   logic       count_valid;
   logic [8:0] bombs_total;
   logic [8:0] revealed_total;
   logic       won;

   modport master (
      output cmd_restart, cmd_move, dir, cmd_flag, cmd_query, cmd_clear,
      input  hbo, hba, rsp_valid, last_cell, busy, cur_row, cur_col,
             neigh_count, count_valid, bombs_total, revealed_total, won
   );

   modport slave (
      input  cmd_restart, cmd_move, dir, cmd_flag, cmd_query, cmd_clear,
      output hbo, hba, rsp_valid, last_cell, busy, cur_row, cur_col,
             neigh_count, count_valid, bombs_total, revealed_total, won
   );
endinterface

// File: rtl/buscaminas_board.sv
// Minesweeper board-state responder: bomb/revealed/flag bits, cursor, neighbour scan.
// Optional macro BOARD_WRAP_EN: cursor moves wrap at the board edges instead of saturating.
//
// state | meaning
// INIT  | walk cells 0..N-1, clear revealed/flag, place bombs from the LFSR
// IDLE  | accept restart/clear/query/flag/move (that priority, one per cycle)
// SCAN  | visit 8 neighbours (idx 0..7), emit count (idx 8), hold count_valid cycle (idx 9)
module buscaminas_board #(
   parameter int         ROWS    = 8,
   parameter int         COLS    = 8,
   parameter int         DENSITY = 40,
   parameter logic [7:0] SEED    = 8'hA5
) (
   input logic               clk,
   input logic               rst,
   buscaminas_board_if.slave bus
);

   localparam int         N       = ROWS * COLS;
   localparam int         AW      = $clog2(N);
   localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
   localparam logic [3:0] COL_MAX = 4'(COLS - 1);
   localparam logic [8:0] DENS    = 9'(DENSITY);

   typedef enum logic [1:0] {INIT, IDLE, SCAN} state_t;

   state_t         state, state_nxt;
   logic [AW-1:0]  a;
   logic [7:0]     lfsr;
   logic [N-1:0]   bomb;
   logic [N-1:0]   revealed;
   logic [N-1:0]   flagged;
   logic [3:0]     cur_row, cur_col;
   logic [3:0]     scan_idx;
   logic [3:0]     scan_cnt;
   logic [3:0]     neigh_count;
   logic           count_valid, last_cell, rsp_valid, hbo, hba;
   logic [8:0]     bombs_total, revealed_total;

   logic           do_restart, init_wr, init_done;
   logic           do_clear, do_query, do_flag, do_move;
   logic           scan_acc, scan_emit;
   logic           lfsr_fb, lfsr_bomb;
   logic [AW-1:0]  cur_idx, nb_idx;
   logic           nb_up, nb_down, nb_left, nb_right, nb_ok, nb_hit;
   logic [3:0]     nb_row, nb_col;
   logic [3:0]     row_mv, col_mv;
   logic           cell_free;

   function automatic logic [AW-1:0] cell_at(input logic [3:0] r, input logic [3:0] c);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign lfsr_bomb = ({1'b0, lfsr} < DENS);

   assign cur_idx   = cell_at(cur_row, cur_col);
   assign cell_free = !revealed[cur_idx] && !flagged[cur_idx];

   always_comb begin
      nb_up    = 1'b0;
      nb_down  = 1'b0;
      nb_left  = 1'b0;
      nb_right = 1'b0;
      case (scan_idx[2:0])
         3'd0: begin nb_up = 1'b1;   nb_left  = 1'b1; end
         3'd1: nb_up = 1'b1;
         3'd2: begin nb_up = 1'b1;   nb_right = 1'b1; end
         3'd3: nb_left = 1'b1;
         3'd4: nb_right = 1'b1;
         3'd5: begin nb_down = 1'b1; nb_left  = 1'b1; end
         3'd6: nb_down = 1'b1;
         default: begin nb_down = 1'b1; nb_right = 1'b1; end
      endcase
   end

   // Off-board neighbours never wrap; the gated index is don't-care when !nb_ok.
   assign nb_ok  = !(nb_up && cur_row == 4'd0) && !(nb_down && cur_row == ROW_MAX) &&
                   !(nb_left && cur_col == 4'd0) && !(nb_right && cur_col == COL_MAX);
   assign nb_row = nb_up ? cur_row - 4'd1 : (nb_down ? cur_row + 4'd1 : cur_row);
   assign nb_col = nb_left ? cur_col - 4'd1 : (nb_right ? cur_col + 4'd1 : cur_col);
   assign nb_idx = cell_at(nb_row, nb_col);
   assign nb_hit = nb_ok && bomb[nb_idx];

   always_comb begin
      row_mv = cur_row;
      col_mv = cur_col;
`ifdef BOARD_WRAP_EN
      case (bus.dir)
         2'd0: row_mv = (cur_row == 4'd0)    ? ROW_MAX : cur_row - 4'd1;
         2'd1: row_mv = (cur_row == ROW_MAX) ? 4'd0    : cur_row + 4'd1;
         2'd2: col_mv = (cur_col == 4'd0)    ? COL_MAX : cur_col - 4'd1;
         default: col_mv = (cur_col == COL_MAX) ? 4'd0 : cur_col + 4'd1;
      endcase
`else
      case (bus.dir)
         2'd0: if (cur_row != 4'd0)    row_mv = cur_row - 4'd1;
         2'd1: if (cur_row != ROW_MAX) row_mv = cur_row + 4'd1;
         2'd2: if (cur_col != 4'd0)    col_mv = cur_col - 4'd1;
         default: if (cur_col != COL_MAX) col_mv = cur_col + 4'd1;
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_restart = 1'b0;
      init_wr    = 1'b0;
      init_done  = 1'b0;
      do_clear   = 1'b0;
      do_query   = 1'b0;
      do_flag    = 1'b0;
      do_move    = 1'b0;
      scan_acc   = 1'b0;
      scan_emit  = 1'b0;
      if (bus.cmd_restart) begin
         do_restart = 1'b1;
         state_nxt  = INIT;
      end else begin
         case (state)
            INIT: begin
               init_wr = 1'b1;
               if (a == AW'(N - 1)) begin
                  init_done = 1'b1;
                  state_nxt = IDLE;
               end
            end
            IDLE: begin
               // A clear on a handled cell still wins priority; it just does nothing.
               if (bus.cmd_clear) begin
                  if (cell_free) begin
                     do_clear  = 1'b1;
                     state_nxt = SCAN;
                  end
               end else if (bus.cmd_query) begin
                  do_query = 1'b1;
               end else if (bus.cmd_flag) begin
                  do_flag = 1'b1;
               end else if (bus.cmd_move) begin
                  do_move = 1'b1;
               end
            end
            SCAN: begin
               if (scan_idx < 4'd8)       scan_acc  = 1'b1;
               else if (scan_idx == 4'd8) scan_emit = 1'b1;
               else                       state_nxt = IDLE;
            end
            default: state_nxt = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a              <= '0;
         lfsr           <= SEED;
         bomb           <= '0;
         revealed       <= '0;
         flagged        <= '0;
         cur_row        <= 4'd0;
         cur_col        <= 4'd0;
         scan_idx       <= 4'd0;
         scan_cnt       <= 4'd0;
         neigh_count    <= 4'd0;
         count_valid    <= 1'b0;
         last_cell      <= 1'b0;
         rsp_valid      <= 1'b0;
         hbo            <= 1'b0;
         hba            <= 1'b0;
         bombs_total    <= 9'd0;
         revealed_total <= 9'd0;
      end else begin
         last_cell   <= init_done;
         rsp_valid   <= do_query;
         count_valid <= scan_emit;

         if (do_restart) begin
            a              <= '0;
            bombs_total    <= 9'd0;
            revealed_total <= 9'd0;
         end

         if (init_wr) begin
            revealed[a] <= 1'b0;
            flagged[a]  <= 1'b0;
            bomb[a]     <= lfsr_bomb;
            if (lfsr_bomb) bombs_total <= bombs_total + 9'd1;
            lfsr <= {lfsr[6:0], lfsr_fb};
            a    <= a + AW'(1);
         end

         if (init_done) begin
            a       <= '0;
            cur_row <= 4'd0;
            cur_col <= 4'd0;
         end

         if (do_query) begin
            hbo <= bomb[cur_idx];
            hba <= revealed[cur_idx] | flagged[cur_idx];
         end

         if (do_flag && !revealed[cur_idx]) flagged[cur_idx] <= ~flagged[cur_idx];

         if (do_move) begin
            cur_row <= row_mv;
            cur_col <= col_mv;
         end

         if (do_clear) begin
            revealed[cur_idx] <= 1'b1;
            flagged[cur_idx]  <= 1'b0;
            revealed_total    <= revealed_total + 9'd1;
            scan_idx          <= 4'd0;
            scan_cnt          <= 4'd0;
         end

         if (scan_acc) begin
            scan_cnt <= scan_cnt + {3'd0, nb_hit};
            scan_idx <= scan_idx + 4'd1;
         end

         if (scan_emit) begin
            neigh_count <= scan_cnt;
            scan_idx    <= scan_idx + 4'd1;
         end
      end
   end

   assign bus.busy           = (state != IDLE);
   assign bus.won            = (revealed_total == (9'(N) - bombs_total));
   assign bus.hbo            = hbo;
   assign bus.hba            = hba;
   assign bus.rsp_valid      = rsp_valid;
   assign bus.last_cell      = last_cell;
   assign bus.cur_row        = cur_row;
   assign bus.cur_col        = cur_col;
   assign bus.neigh_count    = neigh_count;
   assign bus.count_valid    = count_valid;
   assign bus.bombs_total    = bombs_total;
   assign bus.revealed_total = revealed_total;

endmodule
